lse_div_simd_pipe: RTL and testbench
====================================

# lse_div_simd_pipe

- Streaming, pipelined SIMD log-domain divider: computes per-lane `A − B` on 24-bit log-encoded operands, which is division in the linear domain.
- This is the inverse of the combinational SIMD log-domain multiplier (adder); lane partitioning is identical.
- Adds valid/ready handshaking, a 2-stage pipeline, per-lane borrow flags and optional clamp-at-zero.
- Sits between the operand fetch stage and the LSE result writeback.

## Interface
Parameters:
- `SAT_ZERO`, default 0 — 0: lanes wrap modulo 2^w on borrow; 1: a lane that borrows outputs 0.

Ports:
- `i_clk`  in  1  — clock.
- `i_rst_n`  in  1  — reset. One clock; reset is asynchronous and active-low.
- `i_valid`  in  1  — upstream operand beat valid.
- `o_ready`  out  1  — block can accept a beat.
- `i_operand_a`  in  24  — minuend (log domain).
- `i_operand_b`  in  24  — subtrahend (log domain).
- `i_simd_mode`  in  2  — 00: 1×24; 01: 2×12; 10: 4×6; 11: reserved.
- `o_valid`  out  1  — result beat valid.
- `i_ready`  in  1  — downstream accepts the result.
- `o_result`  out  24  — per-lane difference.
- `o_lane_borrow`  out  4  — bit k set when lane k has `a < b` (unsigned).
- `o_mode_err`  out  1  — the beat carried reserved mode 11.

## Operation
- Input transfer happens when `i_valid && o_ready`; output transfer when `o_valid && i_ready`.
- Mode, A and B are captured together; each beat carries its own mode.
- Lane layout:
  - Mode 00: bits [23:0].
  - Mode 01: lanes [11:0] and [23:12].
  - Mode 10: lanes [5:0], [11:6], [17:12], [23:18].
- No borrow propagates across lane boundaries.
- Per lane:
  - `diff = {1'b0,a_lane} − {1'b0,b_lane}`.
  - Borrow = `diff[w]`.
  - Result = `diff[w-1:0]`, or 0 when `SAT_ZERO=1` and the lane borrowed.
- Borrow bit mapping:
  - Mode 00: only bit 0 can be set.
  - Mode 01: bits [1:0] only.
  - Mode 10: all 4 bits.
  - Unused bits are 0.
- Mode 11: `o_result=0`, `o_lane_borrow=0`, `o_mode_err=1`. The beat still transfers normally, with no stall and no drop.
- Beats leave in strict arrival order; none are lost or duplicated.

## Timing
- Stage 1 registers operands and mode. Stage 2 registers result, borrow and error.
- Latency is 2 cycles from input transfer to `o_valid` when there is no backpressure. Throughput is 1 beat/cycle.
- Stall rule:
  - Stage 2 advances when it is empty or `i_ready=1`.
  - Stage 1 advances when stage 2 advances or stage 1 is empty.
  - `o_ready = !s1_valid || s1_advance`. This may combinationally depend on `i_ready`; no other combinational in→out path is allowed.
- With `i_ready=0` the pipeline holds 2 beats and then deasserts `o_ready`.
- While `o_valid=1 && i_ready=0`, all outputs stay stable.
- Simultaneous input and output transfer on a full pipeline: both complete in the same cycle, and occupancy is unchanged.
- Reset values (asserted asynchronously, released synchronously to `i_clk`):
  - `o_valid=0`, `o_result=0`, `o_lane_borrow=0`, `o_mode_err=0`.
  - Both stage valid bits are 0.
  - `o_ready=1` from the first cycle after release.
- Reset mid-operation: in-flight beats are discarded, with no partial output.

## Structure
- Shared package `lse_simd_pkg`:
  - Enum `simd_mode_e`: `SIMD_1X24=2'b00`, `SIMD_2X12=2'b01`, `SIMD_4X6=2'b10`, `SIMD_RSVD=2'b11`.
  - Constants `LSE_W=24`, `LANE12_W=12`, `LANE6_W=6`, `MAX_LANES=4`.
  - The multiplier uses the same package.
- Sub-module `lse_sub_simd`: purely combinational lane-split subtractor producing result, borrow and error. The top level holds only the pipeline and handshake logic.

## Test plan
- Basic paths, `SAT_ZERO=0`:
  - Mode 00, A=000123, B=000111 → result 000012, borrow 0000, exactly 2 cycles after input transfer.
  - Mode 01, A=ABCDEF, B=111111 → result 9ABCDE, borrow 0000.
- Lane isolation:
  - Mode 01, A=000FFF, B=001000 → `SAT_ZERO=0`: result FFFFFF, borrow 0010. `SAT_ZERO=1`: result 000FFF, borrow 0010.
  - Mode 10, A=000000, B=010101 → result 030F3F, borrow 0111.
- Mode 11, any operands → result 000000, borrow 0000, `o_mode_err=1`. The next beat in mode 00 has `o_mode_err=0`.
- Backpressure:
  - Hold `i_ready=0` and offer 3 beats back-to-back → 2 accepted, `o_ready=0`, outputs stable.
  - Release `i_ready` → all 3 beats emerge in order, with no gaps once streaming.
- Reset: pull `i_rst_n` low with 2 beats in flight → `o_valid` drops immediately. After release, `o_ready=1` and no stale beat appears.

Source files
------------

// File: rtl/lse_simd_pkg.sv
// Shared definitions for the SIMD log-domain arithmetic blocks (the multiplier
// and the pipelined divider).
// Contents:
//   simd_mode_e     - lane partitioning of a 24-bit log-encoded operand
//   LSE_W .. LANE6_W, MAX_LANES - operand and lane geometry
//   lse_operand_t   - one captured input beat (operands + mode)
//   lse_result_t    - one result beat (difference, per-lane borrow, mode error)
package lse_simd_pkg;

  localparam int LSE_W     = 24;
  localparam int LANE12_W  = 12;
  localparam int LANE6_W   = 6;
  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {
    SIMD_1X24 = 2'b00,
    SIMD_2X12 = 2'b01,
    SIMD_4X6  = 2'b10,
    SIMD_RSVD = 2'b11
  } simd_mode_e;

  typedef struct packed {
    logic [LSE_W-1:0] a;
    logic [LSE_W-1:0] b;
    simd_mode_e       mode;
  } lse_operand_t;

  typedef struct packed {
    logic [LSE_W-1:0]     result;
    logic [MAX_LANES-1:0] borrow;
    logic                 mode_err;
  } lse_result_t;

endpackage

// File: rtl/lse_sub_simd.sv
// Combinational lane-split subtractor for log-domain division (A - B per lane).
// Ports:
//   i_operand_a   - minuend, 24 bits
//   i_operand_b   - subtrahend, 24 bits
//   i_simd_mode   - lane partitioning (1x24, 2x12, 4x6, reserved)
//   o_result      - per-lane difference (wrapped, or 0 on borrow when SAT_ZERO)
//   o_lane_borrow - bit k set when lane k has a < b; unused lanes read 0
//   o_mode_err    - reserved mode; result and borrow are forced to 0
module lse_sub_simd
  import lse_simd_pkg::*;
#(
  parameter bit SAT_ZERO = 1'b0
) (
  input  logic [LSE_W-1:0]     i_operand_a,
  input  logic [LSE_W-1:0]     i_operand_b,
  input  simd_mode_e           i_simd_mode,
  output logic [LSE_W-1:0]     o_result,
  output logic [MAX_LANES-1:0] o_lane_borrow,
  output logic                 o_mode_err
);

  // Every partitioning is computed in parallel with one extra bit per lane;
  // that top bit is the lane borrow, so nothing ever carries across lanes.
  logic [LSE_W:0]    diff24;
  logic [LANE12_W:0] diff12 [2];
  logic [LANE6_W:0]  diff6  [MAX_LANES];

  assign diff24 = {1'b0, i_operand_a} - {1'b0, i_operand_b};

  for (genvar k = 0; k < 2; k++) begin : g_lane12
    assign diff12[k] = {1'b0, i_operand_a[k*LANE12_W +: LANE12_W]}
                     - {1'b0, i_operand_b[k*LANE12_W +: LANE12_W]};
  end

  for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane6
    assign diff6[k] = {1'b0, i_operand_a[k*LANE6_W +: LANE6_W]}
                    - {1'b0, i_operand_b[k*LANE6_W +: LANE6_W]};
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    o_result      = '0;
    o_lane_borrow = '0;
    o_mode_err    = 1'b0;
    case (i_simd_mode)
      SIMD_1X24: begin
        o_lane_borrow[0] = diff24[LSE_W];
        o_result         = (SAT_ZERO && diff24[LSE_W]) ? '0 : diff24[LSE_W-1:0];
      end
      SIMD_2X12: begin
        for (int k = 0; k < 2; k++) begin
          o_lane_borrow[k] = diff12[k][LANE12_W];
          o_result[k*LANE12_W +: LANE12_W] =
            (SAT_ZERO && diff12[k][LANE12_W]) ? '0 : diff12[k][LANE12_W-1:0];
        end
      end
      SIMD_4X6: begin
        for (int k = 0; k < MAX_LANES; k++) begin
          o_lane_borrow[k] = diff6[k][LANE6_W];
          o_result[k*LANE6_W +: LANE6_W] =
            (SAT_ZERO && diff6[k][LANE6_W]) ? '0 : diff6[k][LANE6_W-1:0];
        end
      end
      default: o_mode_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lse_div_simd_pipe.sv
// Streaming 2-stage SIMD log-domain divider with valid/ready handshaking.
// Stage 1 holds the captured operands and mode; stage 2 holds the result.
// Ports:
//   i_clk, i_rst_n         - clock, asynchronous active-low reset
//   i_valid / o_ready      - input beat handshake
//   i_operand_a/b, i_simd_mode - beat payload, captured together
//   o_valid / i_ready      - output beat handshake
//   o_result, o_lane_borrow, o_mode_err - result beat payload
// o_ready depends combinationally on i_ready; no other input reaches an output
// without passing through a register.
module lse_div_simd_pipe
  import lse_simd_pkg::*;
#(
  parameter bit SAT_ZERO = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [LSE_W-1:0]     i_operand_a,
  input  logic [LSE_W-1:0]     i_operand_b,
  input  logic [1:0]           i_simd_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LSE_W-1:0]     o_result,
  output logic [MAX_LANES-1:0] o_lane_borrow,
  output logic                 o_mode_err
);

  lse_operand_t s1_q, s1_d;
  logic         s1_valid_q, s1_valid_d;
  lse_result_t  s2_q, s2_d;
  logic         s2_valid_q, s2_valid_d;
  lse_result_t  sub_res;
  logic         s1_advance;
  logic         s2_advance;

  lse_sub_simd #(
    .SAT_ZERO(SAT_ZERO)
  ) u_sub (
    .i_operand_a  (s1_q.a),
    .i_operand_b  (s1_q.b),
    .i_simd_mode  (s1_q.mode),
    .o_result     (sub_res.result),
    .o_lane_borrow(sub_res.borrow),
    .o_mode_err   (sub_res.mode_err)
  );

  // A stage may load when its current content is gone (empty or moving on).
  assign s2_advance = !s2_valid_q || i_ready;
  assign s1_advance = s2_advance || !s1_valid_q;
  assign o_ready    = !s1_valid_q || s1_advance;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;

    if (s1_advance) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_d.a    = i_operand_a;
        s1_d.b    = i_operand_b;
        s1_d.mode = simd_mode_e'(i_simd_mode);
      end
    end

    // Payload is only reloaded with a real beat, so a held result never
    // changes while the consumer is stalling.
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = sub_res;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  // NOTE: payload registers are reset as well as the valid bits, so the result
  // outputs read 0 out of reset instead of X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign o_valid       = s2_valid_q;
  assign o_result      = s2_q.result;
  assign o_lane_borrow = s2_q.borrow;
  assign o_mode_err    = s2_q.mode_err;

endmodule

// File: tb/tb_lse_div_simd_pipe.sv
// Self-checking bench for lse_div_simd_pipe. Two instances (wrap and
// clamp-at-zero) share the same stimulus; a scoreboard queue holds the
// expected result of every accepted beat and is compared on output transfer.
module tb_lse_div_simd_pipe;

  typedef struct {
    logic [23:0] res0;     // expected result, SAT_ZERO=0
    logic [23:0] res1;     // expected result, SAT_ZERO=1
    logic [3:0]  borrow;
    logic        err;
    logic        chk_lat;  // check 2-cycle latency for this beat
    int          in_cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] res0;
    logic [23:0] res1;
    logic [3:0]  borrow;
    logic        err;
  } vec_t;

  localparam int NVEC = 10;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [23:0] i_operand_a = '0;
  logic [23:0] i_operand_b = '0;
  logic [1:0]  i_simd_mode = '0;

  logic        o_ready0, o_valid0, o_mode_err0;
  logic [23:0] o_result0;
  logic [3:0]  o_lane_borrow0;
  logic        o_ready1, o_valid1, o_mode_err1;
  logic [23:0] o_result1;
  logic [3:0]  o_lane_borrow1;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t vec[NVEC];
  logic rand_done = 1'b0;

  always #5 i_clk = ~i_clk;

  lse_div_simd_pipe #(.SAT_ZERO(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready0),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_simd_mode(i_simd_mode),
    .o_valid(o_valid0), .i_ready(i_ready), .o_result(o_result0),
    .o_lane_borrow(o_lane_borrow0), .o_mode_err(o_mode_err0)
  );

  lse_div_simd_pipe #(.SAT_ZERO(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready1),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_simd_mode(i_simd_mode),
    .o_valid(o_valid1), .i_ready(i_ready), .o_result(o_result1),
    .o_lane_borrow(o_lane_borrow1), .o_mode_err(o_mode_err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: lane-by-lane unsigned compare and masked subtraction.
  function automatic exp_t model(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b);
    exp_t        r;
    int          n, w;
    logic [31:0] mask, al, bl;
    r.res0 = '0; r.res1 = '0; r.borrow = '0; r.err = 1'b0; r.chk_lat = 1'b0; r.in_cyc = 0;
    if (m == 2'b11) begin
      r.err = 1'b1;
      return r;
    end
    n    = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    w    = 24 / n;
    mask = (32'd1 << w) - 32'd1;
    for (int k = 0; k < n; k++) begin
      al = ({8'd0, a} >> (k * w)) & mask;
      bl = ({8'd0, b} >> (k * w)) & mask;
      if (al < bl) r.borrow[k] = 1'b1;
      r.res0 |= 24'(((al - bl) & mask) << (k * w));
      if (al >= bl) r.res1 |= 24'((al - bl) << (k * w));
    end
    return r;
  endfunction

  function automatic exp_t from_vec(input vec_t v, input logic lat);
    exp_t r;
    r.res0 = v.res0; r.res1 = v.res1; r.borrow = v.borrow; r.err = v.err;
    r.chk_lat = lat; r.in_cyc = 0;
    return r;
  endfunction

  // Scoreboard monitor, sampling mid-cycle (negedge).
  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (o_valid0 && i_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got result %h with empty scoreboard (t=%0t)", o_result0, $time);
        end else begin
          mon_e = sb.pop_front();
          check("result_wrap",  32'(o_result0),      32'(mon_e.res0));
          check("result_sat",   32'(o_result1),      32'(mon_e.res1));
          check("borrow_wrap",  32'(o_lane_borrow0), 32'(mon_e.borrow));
          check("borrow_sat",   32'(o_lane_borrow1), 32'(mon_e.borrow));
          check("mode_err",     32'(o_mode_err0),    32'(mon_e.err));
          check("valid_sat",    32'(o_valid1),       32'd1);
          if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.in_cyc), 32'd2);
        end
      end
      if (i_valid && o_ready0) begin
        mon_e        = cur_exp;
        mon_e.in_cyc = cyc;
        sb.push_back(mon_e);
      end
    end
  end

  // Hold a beat on the input until it is accepted (bounded).
  task automatic send(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b, input exp_t ex);
    logic acc;
    i_simd_mode = m; i_operand_a = a; i_operand_b = b; cur_exp = ex; i_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge i_clk);
      acc = o_ready0;
      @(posedge i_clk);
      #1;
      if (acc) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout: o_ready stayed 0, expected 1 within 64 cycles");
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge i_clk);
      #2;
      if (sb.size() == 0 && !o_valid0) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t ex;
    logic [1:0]  rm;
    logic [23:0] ra, rb;

    //            mode   a          b          res0       res1       borrow   err
    vec[0] = '{2'b00, 24'h000123, 24'h000111, 24'h000012, 24'h000012, 4'b0000, 1'b0};
    vec[1] = '{2'b01, 24'hABCDEF, 24'h111111, 24'h9ABCDE, 24'h9ABCDE, 4'b0000, 1'b0};
    vec[2] = '{2'b01, 24'h000FFF, 24'h001000, 24'hFFFFFF, 24'h000FFF, 4'b0010, 1'b0};
    vec[3] = '{2'b10, 24'h000000, 24'h010101, 24'h030F3F, 24'h000000, 4'b0111, 1'b0};
    vec[4] = '{2'b11, 24'h123456, 24'h654321, 24'h000000, 24'h000000, 4'b0000, 1'b1};
    vec[5] = '{2'b00, 24'hABCDEF, 24'hABCDEF, 24'h000000, 24'h000000, 4'b0000, 1'b0};
    vec[6] = '{2'b00, 24'h000000, 24'h000001, 24'hFFFFFF, 24'h000000, 4'b0001, 1'b0};
    vec[7] = '{2'b01, 24'h800800, 24'h800801, 24'h000FFF, 24'h000000, 4'b0001, 1'b0};
    vec[8] = '{2'b10, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 4'b0000, 1'b0};
    vec[9] = '{2'b10, 24'h820820, 24'h041041, 24'h7DF7DF, 24'h7DF7DF, 4'b0000, 1'b0};
    cur_exp = from_vec(vec[0], 1'b0);

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid",  32'(o_valid0),       32'd0);
    check("rst_result", 32'(o_result0),      32'd0);
    check("rst_borrow", 32'(o_lane_borrow0), 32'd0);
    check("rst_err",    32'(o_mode_err0),    32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready", 32'(o_ready0), 32'd1);
    @(posedge i_clk);
    #1;

    // Table vectors back-to-back, no backpressure, latency checked
    i_ready = 1'b1;
    for (int i = 0; i < NVEC; i++)
      send(vec[i].mode, vec[i].a, vec[i].b, from_vec(vec[i], 1'b1));
    i_valid = 1'b0;
    drain();

    // Backpressure: 2 beats fill the pipe, third is refused, outputs hold
    i_ready = 1'b0;
    send(vec[2].mode, vec[2].a, vec[2].b, from_vec(vec[2], 1'b0));
    send(vec[3].mode, vec[3].a, vec[3].b, from_vec(vec[3], 1'b0));
    i_simd_mode = vec[0].mode; i_operand_a = vec[0].a; i_operand_b = vec[0].b;
    cur_exp = from_vec(vec[0], 1'b0); i_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge i_clk);
      check("bp_ready",  32'(o_ready0),       32'd0);
      check("bp_valid",  32'(o_valid0),       32'd1);
      check("bp_result", 32'(o_result0),      32'(vec[2].res0));
      check("bp_borrow", 32'(o_lane_borrow0), 32'(vec[2].borrow));
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(negedge i_clk);
    check("stream_0", 32'(o_valid0), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("stream_1", 32'(o_valid0), 32'd1);
    @(negedge i_clk);
    check("stream_2", 32'(o_valid0), 32'd1);
    drain();

    // Reset with 2 beats in flight
    i_ready = 1'b0;
    send(vec[1].mode, vec[1].a, vec[1].b, from_vec(vec[1], 1'b0));
    send(vec[6].mode, vec[6].a, vec[6].b, from_vec(vec[6], 1'b0));
    i_valid = 1'b0;
    @(negedge i_clk);
    check("pre_rst_valid", 32'(o_valid0), 32'd1);
    check("pre_rst_ready", 32'(o_ready0), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid",  32'(o_valid0),  32'd0);
    check("mid_rst_valid1", 32'(o_valid1),  32'd0);
    check("mid_rst_result", 32'(o_result0), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(negedge i_clk);
    check("post_rst_ready", 32'(o_ready0), 32'd1);
    for (int t = 0; t < 5; t++) begin
      @(negedge i_clk);
      check("no_stale", 32'(o_valid0), 32'd0);
    end
    @(posedge i_clk);
    #1;

    // Random traffic with random backpressure, checked against the model
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rm = 2'($urandom_range(0, 3));
          ra = 24'($urandom);
          rb = ($urandom_range(0, 7) == 0) ? ra : 24'($urandom);
          ex = model(rm, ra, rb);
          send(rm, ra, rb, ex);
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge i_clk);
            #1;
          end
        end
        i_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
